// File: rtl/pfq_pkg.sv
// Shared types and default constants for the prefetch issue queue.
// Holds the issue-FSM state encoding, default geometry and the
// line-address typedef used by prefetch_issue_queue and pfq_fifo.
package pfq_pkg;

    localparam int unsigned PFQ_DEPTH        = 4;
    localparam int unsigned PFQ_ADDR_W       = 32;
    localparam int unsigned PFQ_BLOCK_OFFSET = 4;
    localparam int unsigned PFQ_CNT_W        = 8;

    // Issue FSM state encoding
    typedef logic [1:0] pfq_state_t;
    localparam pfq_state_t ST_IDLE = 2'd0;
    localparam pfq_state_t ST_REQ  = 2'd1;
    localparam pfq_state_t ST_WAIT = 2'd2;

    // Line address (block-offset bits stripped) at the default geometry
    typedef logic [PFQ_ADDR_W-PFQ_BLOCK_OFFSET-1:0] pfq_line_t;

endpackage

// File: rtl/pfq_fifo.sv
// Circular buffer for line-aligned prefetch addresses.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, din       write din at tail (caller guarantees !full)
//   pop             drop head entry (caller guarantees !empty)
//   head            current head entry
//   cmp, match      match=1 when any valid entry equals cmp
//   count/full/empty registered occupancy status
module pfq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    input  logic [W-1:0]  cmp,
    output logic          match,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;

    assign head      = mem[rd_ptr];
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Entry storage; contents are only meaningful inside the valid window
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Entry i is valid when its distance from the head is below count
    always_comb begin
        logic [PW-1:0] off;
        match = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (mem[i] == cmp)) match = 1'b1;
        end
    end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: buffers line-aligned next-line prefetch addresses
// and issues them one at a time to the next memory level (req/ack), then
// reports the completed fill (done -> fill_valid pulse). Excess prefetches
// are dropped and counted; the prefetcher is never stalled.
// Optional build macro: PFQ_DEDUP_EN -- discard prefetches whose line is
// already queued or in flight, without counting them as drops.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   pf_miss, pf_addr       enqueue strobe and raw prefetch address
//   mem_req, mem_addr      request to memory (addr stable while req=1)
//   mem_ack, mem_done      request accepted / fill finished
//   fill_valid, fill_addr  one-cycle completion pulse with its address
//   q_count/q_full/q_empty queue occupancy
//   drop_cnt               saturating count of dropped enqueues
module prefetch_issue_queue
    import pfq_pkg::*;
#(
    parameter int unsigned DEPTH        = PFQ_DEPTH,
    parameter int unsigned ADDR_W       = PFQ_ADDR_W,
    parameter int unsigned BLOCK_OFFSET = PFQ_BLOCK_OFFSET,
    parameter int unsigned CNT_W        = PFQ_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pf_miss,
    input  logic [ADDR_W-1:0]          pf_addr,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic                       mem_done,
    output logic                       fill_valid,
    output logic [ADDR_W-1:0]          fill_addr,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       q_full,
    output logic                       q_empty,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-BLOCK_OFFSET){1'b1}}, {BLOCK_OFFSET{1'b0}}};

`ifdef PFQ_DEDUP_EN
    localparam logic DEDUP_EN = 1'b1;
`else
    localparam logic DEDUP_EN = 1'b0;
`endif

    pfq_state_t        state;
    pfq_state_t        state_nxt;
    logic [ADDR_W-1:0] pf_line;
    logic [ADDR_W-1:0] fifo_head;
    logic [ADDR_W-1:0] inflight;
    logic [ADDR_W-1:0] inflight_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [ADDR_W-1:0] fill_addr_nxt;
    logic              mem_req_nxt;
    logic              fill_valid_nxt;
    logic              fifo_match;
    logic              inflight_hit;
    logic              dup;
    logic              push;
    logic              pop;
    logic              drop;

    assign pf_line = pf_addr & LINE_MASK;

    // Duplicate filter: queued entries plus the line currently offered/in flight
    assign inflight_hit = ((state == ST_WAIT) && (inflight == pf_line)) ||
                          ((state == ST_REQ)  && (mem_addr == pf_line));
    assign dup  = DEDUP_EN && pf_miss && (fifo_match || inflight_hit);

    // Fullness uses the pre-edge registered flag, even when popping this edge
    assign push = pf_miss && !dup && !q_full;
    assign drop = pf_miss && !dup &&  q_full;

    pfq_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (pf_line),
        .pop   (pop),
        .head  (fifo_head),
        .cmp   (pf_line),
        .match (fifo_match),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Issue FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Issue FSM next state plus next values of the registered outputs
    always_comb begin
        state_nxt      = state;
        mem_req_nxt    = 1'b0;
        mem_addr_nxt   = mem_addr;
        fill_valid_nxt = 1'b0;
        fill_addr_nxt  = fill_addr;
        inflight_nxt   = inflight;
        pop            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_nxt    = ST_REQ;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = fifo_head;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    pop          = 1'b1;
                    inflight_nxt = mem_addr;
                    state_nxt    = ST_WAIT;
                end else begin
                    mem_req_nxt  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    fill_valid_nxt = 1'b1;
                    fill_addr_nxt  = inflight;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            inflight   <= '0;
        end else begin
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            fill_valid <= fill_valid_nxt;
            fill_addr  <= fill_addr_nxt;
            inflight   <= inflight_nxt;
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        drop_cnt <= '0;
        else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end

endmodule

// File: doc/prefetch_issue_queue.md
# prefetch_issue_queue

Buffers next-line prefetch addresses produced by the prefetcher on a prefetch-buffer miss and issues them, one at a time, to the next memory level over a req/ack handshake. Sits directly downstream of the next-line prefetcher and upstream of the memory port. Reports completed fills back so the prefetch buffer can be marked filled. One request in flight at a time; excess prefetches are dropped and counted, never stalling the prefetcher.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 32, address width
- BLOCK_OFFSET, 4, log2(block size in bytes); low bits cleared on enqueue
- CNT_W, 8, width of drop counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pf_miss  in  1  enqueue strobe (prefetcher's prefetch_miss)
- pf_addr  in  ADDR_W  prefetch address (prefetcher's prefetch_address)
- mem_req  out  1  request valid to memory
- mem_addr  out  ADDR_W  line-aligned request address
- mem_ack  in  1  memory accepted request
- mem_done  in  1  memory finished the fill
- fill_valid  out  1  one-cycle pulse: fill complete
- fill_addr  out  ADDR_W  address of completed fill, valid with fill_valid
- q_count  out  $clog2(DEPTH)+1  entries held
- q_full  out  1  q_count == DEPTH
- q_empty  out  1  q_count == 0
- drop_cnt  out  CNT_W  saturating count of dropped enqueues

## Operation
- Reset: all outputs 0, queue empty (q_empty=1 is the only output at 1), state IDLE. Reset asserted mid-transaction abandons it; no fill_valid.
- Enqueue: pf_miss=1 sampled at edge → {pf_addr[ADDR_W-1:BLOCK_OFFSET], BLOCK_OFFSET'b0} written at tail.
- Drop: pf_miss while q_full → not written, drop_cnt+1 (saturates at all-ones). Full check uses pre-edge count, even if a pop occurs the same edge.
- Issue FSM states:
  - IDLE: mem_req=0. If !q_empty → REQ.
  - REQ: mem_req=1, mem_addr=head. On mem_ack → pop head, latch address as in-flight, → WAIT. mem_addr stable while mem_req=1.
  - WAIT: mem_req=0. On mem_done → fill_valid=1 and fill_addr=in-flight for one cycle, → IDLE.
- mem_ack outside REQ and mem_done outside WAIT are ignored.
- Simultaneous push and pop (not full): both occur; q_count unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- pf_miss sampled at edge N → q_empty=0 after N → FSM enters REQ at N+1 → mem_req high after N+1 (1-cycle enqueue-to-request latency from empty).
- mem_ack sampled at edge M in REQ → mem_req low after M; head popped at M.
- mem_done sampled at edge P in WAIT → fill_valid high for exactly cycle after P; FSM IDLE after P; if queue non-empty, REQ at P+1.
- Minimum back-to-back issue spacing: mem_ack and mem_done on consecutive edges → new mem_req 3 cycles after previous one rose.
- All outputs registered; no combinational path input → output.

## Configuration
- PFQ_DEDUP_EN defined: pf_miss whose line address equals any valid queue entry or the in-flight address (REQ/WAIT) is discarded silently; drop_cnt not incremented. Dedup check is evaluated before the full check.
- Undefined: every pf_miss is enqueued or dropped purely on fullness; duplicates issued.

## Structure
- Package pfq_pkg: issue-state enum (IDLE, REQ, WAIT), line-address typedef, default constants for DEPTH/BLOCK_OFFSET.
- Sub-module pfq_fifo: circular buffer with push/pop, count, full/empty, and a match output (any valid entry == compare address) used only under PFQ_DEDUP_EN.

## Test plan
- Reset: rst_n=0 mid-REQ → mem_req=0 immediately, q_count=0, q_empty=1, drop_cnt=0.
- Single: pf_miss, pf_addr=0x0000_1237 → mem_req one cycle later with mem_addr=0x0000_1230; ack, then done → fill_valid pulse, fill_addr=0x0000_1230.
- Fill: 5 pf_miss (0x100,0x200,0x300,0x400,0x500) with mem_ack held 0 → first popped into REQ only after ack; with DEPTH=4 and no ack, 5th dropped, drop_cnt=1, q_full=1.
- Order/wrap: push 10 distinct addresses interleaved with ack/done → issued in FIFO order, pointers wrap, none lost.
- Dedup (PFQ_DEDUP_EN): 0x2000 in-flight, pf_miss 0x2008 → discarded, q_count=0, drop_cnt unchanged; without macro → enqueued, issued twice.
- Saturation: CNT_W=2, 5 drops → drop_cnt=3.
